// File: rtl/icache_fetch_stage_pkg.sv
// Shared types and PC field-width helpers for the instruction-cache fetch stage.
package icache_fetch_stage_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MISS_REQ = 2'd1,
        REFILL   = 2'd2,
        RESPOND  = 2'd3
    } state_e;

    localparam int BYTE_OFF_W = 2;

    function automatic int word_off_w(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int index_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_w(input int addr_w, input int num_lines, input int words_per_line);
        return addr_w - BYTE_OFF_W - $clog2(num_lines) - $clog2(words_per_line);
    endfunction

endpackage

// File: rtl/icache_fetch_stage_line_ram.sv
// Direct-mapped data and tag storage: one combinational read port, one synchronous write port.
module icache_line_ram
    import icache_fetch_stage_pkg::*;
#(
    parameter int INSTR_W        = 32,
    parameter int TAG_W          = 24,
    parameter int NUM_LINES      = 16,
    parameter int WORDS_PER_LINE = 4,
    localparam int IDX_W         = index_w(NUM_LINES),
    localparam int WOFF_W        = word_off_w(WORDS_PER_LINE)
) (
    input  logic               clk,
    input  logic [IDX_W-1:0]   rd_index,
    input  logic [WOFF_W-1:0]  rd_word,
    output logic [INSTR_W-1:0] rd_data,
    output logic [TAG_W-1:0]   rd_tag,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_index,
    input  logic [WOFF_W-1:0]  wr_word,
    input  logic [INSTR_W-1:0] wr_data,
    input  logic               tag_wr_en,
    input  logic [TAG_W-1:0]   tag_wr_data
);

    logic [INSTR_W-1:0] data_mem [NUM_LINES*WORDS_PER_LINE];
    logic [TAG_W-1:0]   tag_mem  [NUM_LINES];

    assign rd_data = data_mem[{rd_index, rd_word}];
    assign rd_tag  = tag_mem[rd_index];

    // Contents are qualified by the valid bits held in the fetch stage, so no reset here.
    always_ff @(posedge clk) begin
        if (wr_en)     data_mem[{wr_index, wr_word}] <= wr_data;
        if (tag_wr_en) tag_mem[wr_index]             <= tag_wr_data;
    end

endmodule

// File: rtl/icache_fetch_stage.sv
// Blocking instruction-cache fetch stage: 1-cycle hits, single outstanding line refill on miss.
module icache_fetch_stage
    import icache_fetch_stage_pkg::*;
#(
    parameter int WARP_ID_W      = 5,
    parameter int ADDR_W         = 32,
    parameter int INSTR_W        = 32,
    parameter int NUM_LINES      = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_tvalid,
    output logic                 s_tready,
    input  logic                 s_tlast,
    input  logic [WARP_ID_W-1:0] s_warp_id,
    input  logic [ADDR_W-1:0]    s_pc,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic                 m_tlast,
    output logic [WARP_ID_W-1:0] m_warp_id,
    output logic [INSTR_W-1:0]   m_instruction,
    output logic                 m_err,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [ADDR_W-1:0]    mem_req_addr,
    input  logic                 mem_rsp_valid,
    input  logic [INSTR_W-1:0]   mem_rsp_data,
    input  logic                 flush
);

    localparam int WOFF_W   = word_off_w(WORDS_PER_LINE);
    localparam int IDX_W    = index_w(NUM_LINES);
    localparam int TAG_W    = tag_w(ADDR_W, NUM_LINES, WORDS_PER_LINE);
    localparam int LINE_LSB = BYTE_OFF_W + WOFF_W;
    localparam int TAG_LSB  = LINE_LSB + IDX_W;
    localparam logic [WOFF_W-1:0] LAST_BEAT = WOFF_W'(WORDS_PER_LINE - 1);

    state_e                 state_q, state_d;
    logic [NUM_LINES-1:0]   valid_q, valid_d;
    logic [WOFF_W-1:0]      beat_q, beat_d;
    logic                   flushed_q, flushed_d;
    logic [TAG_W-1:0]       req_tag_q, req_tag_d;
    logic [IDX_W-1:0]       req_idx_q, req_idx_d;
    logic [WOFF_W-1:0]      req_word_q, req_word_d;
    logic                   m_tvalid_q, m_tvalid_d;
    logic                   m_tlast_q, m_tlast_d;
    logic [WARP_ID_W-1:0]   m_warp_id_q, m_warp_id_d;
    logic [INSTR_W-1:0]     m_instruction_q, m_instruction_d;
    logic                   m_err_q, m_err_d;
    logic                   mem_req_valid_q, mem_req_valid_d;
    logic [ADDR_W-1:0]      mem_req_addr_q, mem_req_addr_d;

    logic [WOFF_W-1:0]      s_word;
    logic [IDX_W-1:0]       s_idx;
    logic [TAG_W-1:0]       s_tag;
    logic [INSTR_W-1:0]     rd_data;
    logic [TAG_W-1:0]       rd_tag;
    logic                   ram_wr_en, ram_tag_wr_en;
    logic                   xfer, hit;

    assign s_word = s_pc[LINE_LSB-1:BYTE_OFF_W];
    assign s_idx  = s_pc[TAG_LSB-1:LINE_LSB];
    assign s_tag  = s_pc[ADDR_W-1:TAG_LSB];

    assign s_tready = (state_q == IDLE) && (!m_tvalid_q || m_tready);
    assign xfer     = s_tvalid && s_tready;
    // A flush in the lookup cycle wins over a stale hit.
    assign hit      = valid_q[s_idx] && (rd_tag == s_tag) && !flush;

    icache_line_ram #(
        .INSTR_W        (INSTR_W),
        .TAG_W          (TAG_W),
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_line_ram (
        .clk         (clk),
        .rd_index    (s_idx),
        .rd_word     (s_word),
        .rd_data     (rd_data),
        .rd_tag      (rd_tag),
        .wr_en       (ram_wr_en),
        .wr_index    (req_idx_q),
        .wr_word     (beat_q),
        .wr_data     (mem_rsp_data),
        .tag_wr_en   (ram_tag_wr_en),
        .tag_wr_data (req_tag_q)
    );

    always_comb begin
        state_d         = state_q;
        valid_d         = valid_q;
        beat_d          = beat_q;
        flushed_d       = flushed_q;
        req_tag_d       = req_tag_q;
        req_idx_d       = req_idx_q;
        req_word_d      = req_word_q;
        m_tvalid_d      = m_tvalid_q;
        m_tlast_d       = m_tlast_q;
        m_warp_id_d     = m_warp_id_q;
        m_instruction_d = m_instruction_q;
        m_err_d         = m_err_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_req_addr_d  = mem_req_addr_q;
        ram_wr_en       = 1'b0;
        ram_tag_wr_en   = 1'b0;

        if (flush) valid_d = '0;

        unique case (state_q)
            IDLE: begin
                if (m_tvalid_q && m_tready) m_tvalid_d = 1'b0;
                if (xfer) begin
                    m_warp_id_d = s_warp_id;
                    m_tlast_d   = s_tlast;
                    if (s_pc[BYTE_OFF_W-1:0] != '0) begin
                        m_tvalid_d      = 1'b1;
                        m_err_d         = 1'b1;
                        m_instruction_d = '0;
                    end else if (hit) begin
                        m_tvalid_d      = 1'b1;
                        m_err_d         = 1'b0;
                        m_instruction_d = rd_data;
                    end else begin
                        req_tag_d       = s_tag;
                        req_idx_d       = s_idx;
                        req_word_d      = s_word;
                        flushed_d       = 1'b0;
                        mem_req_valid_d = 1'b1;
                        mem_req_addr_d  = {s_pc[ADDR_W-1:LINE_LSB], {LINE_LSB{1'b0}}};
                        state_d         = MISS_REQ;
                    end
                end
            end
            MISS_REQ: begin
                if (flush) flushed_d = 1'b1;
                if (mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    beat_d          = '0;
                    state_d         = REFILL;
                end
            end
            REFILL: begin
                if (flush) flushed_d = 1'b1;
                if (mem_rsp_valid) begin
                    ram_wr_en = 1'b1;
                    beat_d    = beat_q + 1'b1;
                    // m_tvalid is low here, so the requested word is latched straight into the output.
                    if (beat_q == req_word_q) m_instruction_d = mem_rsp_data;
                    if (beat_q == LAST_BEAT) begin
                        ram_tag_wr_en = 1'b1;
                        if (!flushed_q && !flush) valid_d[req_idx_q] = 1'b1;
                        m_tvalid_d = 1'b1;
                        m_err_d    = 1'b0;
                        state_d    = RESPOND;
                    end
                end
            end
            RESPOND: begin
                if (m_tready) begin
                    m_tvalid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            valid_q         <= '0;
            beat_q          <= '0;
            flushed_q       <= 1'b0;
            req_tag_q       <= '0;
            req_idx_q       <= '0;
            req_word_q      <= '0;
            m_tvalid_q      <= 1'b0;
            m_tlast_q       <= 1'b0;
            m_warp_id_q     <= '0;
            m_instruction_q <= '0;
            m_err_q         <= 1'b0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
        end else begin
            state_q         <= state_d;
            valid_q         <= valid_d;
            beat_q          <= beat_d;
            flushed_q       <= flushed_d;
            req_tag_q       <= req_tag_d;
            req_idx_q       <= req_idx_d;
            req_word_q      <= req_word_d;
            m_tvalid_q      <= m_tvalid_d;
            m_tlast_q       <= m_tlast_d;
            m_warp_id_q     <= m_warp_id_d;
            m_instruction_q <= m_instruction_d;
            m_err_q         <= m_err_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_addr_q  <= mem_req_addr_d;
        end
    end

    assign m_tvalid      = m_tvalid_q;
    assign m_tlast       = m_tlast_q;
    assign m_warp_id     = m_warp_id_q;
    assign m_instruction = m_instruction_q;
    assign m_err         = m_err_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_addr  = mem_req_addr_q;

endmodule

// File: tb/tb_icache_fetch_stage.sv
// Scoreboard bench for icache_fetch_stage: hit, miss/refill, backpressure, flush, misalign, reset.
module tb_icache_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        s_tlast = 1'b0;
    logic [4:0]  s_warp_id = '0;
    logic [31:0] s_pc = '0;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tlast;
    logic [4:0]  m_warp_id;
    logic [31:0] m_instruction;
    logic        m_err;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic        flush = 1'b0;

    typedef struct packed {
        logic [4:0]  warp;
        logic [31:0] instr;
        logic        err;
        logic        last;
    } resp_t;

    resp_t sb[$];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    icache_fetch_stage dut (
        .clk(clk), .rst_n(rst_n),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .s_warp_id(s_warp_id), .s_pc(s_pc),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .m_warp_id(m_warp_id), .m_instruction(m_instruction), .m_err(m_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data), .flush(flush)
    );

    // Present a request from a negedge and hold it until the DUT accepts it.
    task automatic send_req(input logic [4:0] warp, input logic [31:0] pc, input logic last,
                            input logic fl);
        s_tvalid = 1'b1; s_warp_id = warp; s_pc = pc; s_tlast = last; flush = fl;
        for (int i = 0; i < 50; i++) begin
            if (s_tready) break;
            @(negedge clk);
        end
        @(negedge clk);
        s_tvalid = 1'b0; flush = 1'b0;
    endtask

    task automatic serve_refill(input int nbeats, input logic [31:0] base, input int flush_at,
                                output bit got, output logic [31:0] addr);
        got = 1'b0; addr = '0;
        for (int i = 0; i < 50; i++) begin
            if (mem_req_valid) begin got = 1'b1; break; end
            @(negedge clk);
        end
        if (!got) return;
        addr = mem_req_addr;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            mem_rsp_valid = 1'b1; mem_rsp_data = base + 32'(i); flush = (i == flush_at);
            @(negedge clk);
        end
        mem_rsp_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic get_resp(output bit ok, output resp_t r, output int waited);
        ok = 1'b0; r = '0; waited = 0;
        for (int i = 0; i < 50; i++) begin
            if (m_tvalid) begin
                ok = 1'b1;
                r = '{warp: m_warp_id, instr: m_instruction, err: m_err, last: m_tlast};
                @(negedge clk);
                return;
            end
            waited++;
            @(negedge clk);
        end
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL reset_m_tvalid got=%0b exp=0", m_tvalid); end
        total++; if (m_err !== 1'b0 || m_tlast !== 1'b0) begin bad++; $display("FAIL reset_err_last got=%0b%0b exp=00", m_err, m_tlast); end
        total++; if (mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_req got=%0b/%h exp=0/0", mem_req_valid, mem_req_addr); end
        total++; if (m_warp_id !== 5'd0 || m_instruction !== 32'h0) begin bad++; $display("FAIL reset_m_data got=%0d/%h exp=0/0", m_warp_id, m_instruction); end
        total++; if (s_tready !== 1'b1) begin bad++; $display("FAIL reset_s_tready got=%0b exp=1", s_tready); end
    endtask

    // Issue a request expected to miss, refill the line and check the single response.
    task automatic miss_and_check(input string name, input logic [4:0] warp, input logic [31:0] pc,
                                  input logic last, input logic fl, input logic [31:0] base,
                                  input int flush_at, input logic [31:0] exp_instr);
        bit got, ok; logic [31:0] addr; resp_t r, e; int w;
        sb.push_back('{warp: warp, instr: exp_instr, err: 1'b0, last: last});
        send_req(warp, pc, last, fl);
        serve_refill(4, base, flush_at, got, addr);
        total++;
        if (!got || addr !== {pc[31:4], 4'h0}) begin
            bad++; $display("FAIL %s_refill_addr got=%0b/%h exp=1/%h", name, got, addr, {pc[31:4], 4'h0});
        end
        get_resp(ok, r, w);
        e = sb.pop_front();
        total++;
        if (!ok || r !== e) begin
            bad++; $display("FAIL %s_resp got=%0b w%0d i%h e%0b l%0b exp=w%0d i%h e%0b l%0b",
                            name, ok, r.warp, r.instr, r.err, r.last, e.warp, e.instr, e.err, e.last);
        end
    endtask

    task automatic test_cold_miss();
        miss_and_check("cold", 5'd3, 32'h1000, 1'b0, 1'b0, 32'hA0, -1, 32'hA0);
    endtask

    task automatic test_hit();
        bit ok; resp_t r, e; int w;
        sb.push_back('{warp: 5'd7, instr: 32'hA3, err: 1'b0, last: 1'b1});
        send_req(5'd7, 32'h100C, 1'b1, 1'b0);
        total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL hit_no_refill got=%0b exp=0", mem_req_valid); end
        get_resp(ok, r, w);
        e = sb.pop_front();
        total++; if (!ok || w != 0) begin bad++; $display("FAIL hit_latency got=%0b/%0d exp=1/0", ok, w); end
        total++; if (r !== e) begin bad++; $display("FAIL hit_resp got=w%0d i%h e%0b l%0b exp=w%0d i%h e%0b l%0b", r.warp, r.instr, r.err, r.last, e.warp, e.instr, e.err, e.last); end
    endtask

    task automatic test_backpressure();
        bit ok; resp_t r, e; int w;
        sb.push_back('{warp: 5'd2, instr: 32'hA1, err: 1'b0, last: 1'b0});
        m_tready = 1'b0;
        send_req(5'd2, 32'h1004, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (m_tvalid !== 1'b1 || m_instruction !== 32'hA1 || m_warp_id !== 5'd2 || s_tready !== 1'b0) begin
                bad++; $display("FAIL bp_hold_%0d got=v%0b i%h w%0d rdy%0b exp=v1 iA1 w2 rdy0", i, m_tvalid, m_instruction, m_warp_id, s_tready);
            end
            @(negedge clk);
        end
        m_tready = 1'b1;
        get_resp(ok, r, w);
        e = sb.pop_front();
        total++; if (!ok || r !== e) begin bad++; $display("FAIL bp_resp got=%0b i%h w%0d exp=1 i%h w%0d", ok, r.instr, r.warp, e.instr, e.warp); end
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL bp_single got=%0b exp=0", m_tvalid); end
    endtask

    task automatic test_misaligned();
        bit ok; resp_t r, e; int w;
        sb.push_back('{warp: 5'd4, instr: 32'h0, err: 1'b1, last: 1'b0});
        send_req(5'd4, 32'h1002, 1'b0, 1'b0);
        total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL mis_no_refill got=%0b exp=0", mem_req_valid); end
        get_resp(ok, r, w);
        e = sb.pop_front();
        total++; if (!ok || w != 0 || r !== e) begin bad++; $display("FAIL mis_resp got=%0b/%0d i%h e%0b exp=1/0 i%h e%0b", ok, w, r.instr, r.err, e.instr, e.err); end
        // Stray memory beats while idle must not touch the cached line.
        for (int i = 0; i < 2; i++) begin
            mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD0000 + 32'(i);
            @(negedge clk);
        end
        mem_rsp_valid = 1'b0;
        sb.push_back('{warp: 5'd0, instr: 32'hA0, err: 1'b0, last: 1'b0});
        send_req(5'd0, 32'h1000, 1'b0, 1'b0);
        total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL stray_no_refill got=%0b exp=0", mem_req_valid); end
        get_resp(ok, r, w);
        e = sb.pop_front();
        total++; if (!ok || r !== e) begin bad++; $display("FAIL stray_resp got=%0b i%h exp=1 i%h", ok, r.instr, e.instr); end
    endtask

    task automatic test_flush();
        pulse_flush();
        miss_and_check("flush_idle", 5'd5, 32'h1004, 1'b0, 1'b0, 32'hB0, -1, 32'hB1);
        pulse_flush();
        miss_and_check("flush_refill", 5'd6, 32'h1000, 1'b1, 1'b0, 32'hC0, 1, 32'hC0);
        miss_and_check("after_flush_refill", 5'd8, 32'h1000, 1'b0, 1'b0, 32'hD0, -1, 32'hD0);
        miss_and_check("flush_same_cycle", 5'd9, 32'h100C, 1'b0, 1'b1, 32'hE0, -1, 32'hE3);
    endtask

    task automatic test_reset_mid_refill();
        bit got; logic [31:0] addr;
        pulse_flush();
        send_req(5'd1, 32'h1000, 1'b1, 1'b0);
        serve_refill(2, 32'hF0, -1, got, addr);
        total++; if (!got || addr !== 32'h1000) begin bad++; $display("FAIL rst_refill_start got=%0b/%h exp=1/00001000", got, addr); end
        rst_n = 1'b0;
        #1;
        test_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        miss_and_check("after_reset", 5'd2, 32'h1000, 1'b0, 1'b0, 32'hF0, -1, 32'hF0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_cold_miss();
        test_hit();
        test_backpressure();
        test_misaligned();
        test_flush();
        test_reset_mid_refill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
